// File: rtl/gpu_ctrl_pkg.sv
// Shared types and defaults for the GPU host-side control blocks.
// Launch sequencing states and the default DCR/thread-count width live here.
package gpu_ctrl_pkg;

    localparam int unsigned DATA_BITS_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        CONFIG,
        SETTLE,
        RUN,
        REPORT
    } launch_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// count_next exposes the value the counter takes at the coming edge.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next
);

    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (enable && (count != '1)) begin
            count_next = count + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/kernel_launch_ctrl.sv
// Host-facing sequencer for a single kernel launch: reset pulse, DCR write, run with
// watchdog, then a one-cycle status report. All outputs are registered.
module kernel_launch_ctrl
    import gpu_ctrl_pkg::*;
#(
    parameter int unsigned            DATA_BITS      = DATA_BITS_DEFAULT,
    parameter int unsigned            CYCLE_BITS     = 16,
    parameter logic [CYCLE_BITS-1:0]  TIMEOUT_CYCLES = CYCLE_BITS'(16'hFFF0)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  launch_valid,
    output logic                  launch_ready,
    input  logic [DATA_BITS-1:0]  launch_thread_count,
    output logic                  device_control_write_enable,
    output logic [DATA_BITS-1:0]  device_control_data,
    output logic                  kernel_reset,
    output logic                  kernel_start,
    input  logic                  kernel_done,
    output logic                  busy,
    output logic                  status_valid,
    output logic                  status_timeout,
    output logic [CYCLE_BITS-1:0] status_cycles
);

    launch_state_t         state;
    logic [DATA_BITS-1:0]  count_q;
    logic                  accept;
    logic                  in_run;
    logic                  watchdog;
    logic [CYCLE_BITS-1:0] cycles_next;

    assign accept = (state == IDLE) && launch_valid;
    assign in_run = (state == RUN);

    // Compare against the post-increment value so the limit equals the number of RUN cycles.
    assign watchdog = (TIMEOUT_CYCLES != '0) && (cycles_next == TIMEOUT_CYCLES);

    sat_counter #(
        .WIDTH(CYCLE_BITS)
    ) u_cycle_counter (
        .clk       (clk),
        .reset     (reset),
        .clear     (accept),
        .enable    (in_run),
        .count     (status_cycles),
        .count_next(cycles_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                       <= IDLE;
            count_q                     <= '0;
            launch_ready                <= 1'b1;
            busy                        <= 1'b0;
            kernel_reset                <= 1'b0;
            kernel_start                <= 1'b0;
            device_control_write_enable <= 1'b0;
            device_control_data         <= '0;
            status_valid                <= 1'b0;
            status_timeout              <= 1'b0;
        end else begin
            kernel_reset                <= 1'b0;
            device_control_write_enable <= 1'b0;
            device_control_data         <= '0;
            status_valid                <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (launch_valid) begin
                        state          <= CLEAR;
                        count_q        <= launch_thread_count;
                        status_timeout <= 1'b0;
                        launch_ready   <= 1'b0;
                        busy           <= 1'b1;
                        kernel_reset   <= 1'b1;
                    end
                end
                CLEAR: begin
                    state                       <= CONFIG;
                    device_control_write_enable <= 1'b1;
                    device_control_data         <= count_q;
                end
                CONFIG: begin
                    if (count_q == '0) begin
                        state        <= REPORT;
                        status_valid <= 1'b1;
                    end else begin
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    state        <= RUN;
                    kernel_start <= 1'b1;
                end
                RUN: begin
                    if (kernel_done) begin
                        state        <= REPORT;
                        kernel_start <= 1'b0;
                        status_valid <= 1'b1;
                    end else if (watchdog) begin
                        // Hung kernel: report the timeout and reset the cores in REPORT.
                        state          <= REPORT;
                        kernel_start   <= 1'b0;
                        status_valid   <= 1'b1;
                        status_timeout <= 1'b1;
                        kernel_reset   <= 1'b1;
                    end
                end
                REPORT: begin
                    state        <= IDLE;
                    launch_ready <= 1'b1;
                    busy         <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    launch_ready <= 1'b1;
                    busy         <= 1'b0;
                    kernel_start <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kernel_launch_ctrl.sv
// Directed bench for kernel_launch_ctrl: one instance with the default watchdog and one
// with a 4-cycle watchdog, both driven from the same host/dispatcher stimulus.
module tb_kernel_launch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        launch_valid = 1'b0;
    logic [7:0]  launch_thread_count = '0;
    logic        kernel_done = 1'b0;

    logic        m_launch_ready, m_dcr_we, m_kernel_reset, m_kernel_start, m_busy;
    logic        m_status_valid, m_status_timeout;
    logic [7:0]  m_dcr_data;
    logic [15:0] m_status_cycles;

    logic        w_launch_ready, w_dcr_we, w_kernel_reset, w_kernel_start, w_busy;
    logic        w_status_valid, w_status_timeout;
    logic [7:0]  w_dcr_data;
    logic [15:0] w_status_cycles;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    kernel_launch_ctrl u_main (
        .clk                        (clk),
        .reset                      (reset),
        .launch_valid               (launch_valid),
        .launch_ready               (m_launch_ready),
        .launch_thread_count        (launch_thread_count),
        .device_control_write_enable(m_dcr_we),
        .device_control_data        (m_dcr_data),
        .kernel_reset               (m_kernel_reset),
        .kernel_start               (m_kernel_start),
        .kernel_done                (kernel_done),
        .busy                       (m_busy),
        .status_valid               (m_status_valid),
        .status_timeout             (m_status_timeout),
        .status_cycles              (m_status_cycles)
    );

    kernel_launch_ctrl #(
        .TIMEOUT_CYCLES(16'd4)
    ) u_wd (
        .clk                        (clk),
        .reset                      (reset),
        .launch_valid               (launch_valid),
        .launch_ready               (w_launch_ready),
        .launch_thread_count        (launch_thread_count),
        .device_control_write_enable(w_dcr_we),
        .device_control_data        (w_dcr_data),
        .kernel_reset               (w_kernel_reset),
        .kernel_start               (w_kernel_start),
        .kernel_done                (kernel_done),
        .busy                       (w_busy),
        .status_valid               (w_status_valid),
        .status_timeout             (w_status_timeout),
        .status_cycles              (w_status_cycles)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        launch_valid = 1'b0;
        kernel_done  = 1'b0;
        reset        = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks += 5;
        if (m_launch_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", m_launch_ready); end
        if (m_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", m_busy); end
        if ({m_dcr_we, m_kernel_reset, m_kernel_start, m_status_valid, m_status_timeout} !== 5'b0) begin
            n_fail++; $display("FAIL rst_flags got %b want 00000",
                {m_dcr_we, m_kernel_reset, m_kernel_start, m_status_valid, m_status_timeout});
        end
        if (m_dcr_data !== 8'd0) begin n_fail++; $display("FAIL rst_dcr_data got %0d want 0", m_dcr_data); end
        if (m_status_cycles !== 16'd0) begin n_fail++; $display("FAIL rst_cycles got %0d want 0", m_status_cycles); end
        // Drive a launch into RUN, then reset asynchronously mid-cycle.
        launch_thread_count = 8'd4;
        launch_valid = 1'b1;
        step();
        launch_valid = 1'b0;
        step(); step(); step(); step();
        n_checks++;
        if (m_kernel_start !== 1'b1) begin n_fail++; $display("FAIL rst_pre_run got %b want 1", m_kernel_start); end
        #2 reset = 1'b1;
        #1;
        n_checks += 4;
        if (m_kernel_start !== 1'b0) begin n_fail++; $display("FAIL rst_async_start got %b want 0", m_kernel_start); end
        if (m_busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy got %b want 0", m_busy); end
        if (m_launch_ready !== 1'b1) begin n_fail++; $display("FAIL rst_async_ready got %b want 1", m_launch_ready); end
        if (m_status_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid got %b want 0", m_status_valid); end
        step();
        reset = 1'b0;
        kernel_done = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (m_status_valid !== 1'b0 || m_busy !== 1'b0) begin
                n_fail++; $display("FAIL rst_no_status got valid=%b busy=%b want 0 0", m_status_valid, m_busy);
            end
        end
        kernel_done = 1'b0;
    endtask

    task automatic test_normal();
        apply_reset();
        launch_thread_count = 8'd8;
        launch_valid = 1'b1;
        step();
        launch_valid = 1'b0;
        n_checks += 3;
        if (m_kernel_reset !== 1'b1) begin n_fail++; $display("FAIL norm_clear_pulse got %b want 1", m_kernel_reset); end
        if (m_busy !== 1'b1) begin n_fail++; $display("FAIL norm_busy got %b want 1", m_busy); end
        if (m_launch_ready !== 1'b0) begin n_fail++; $display("FAIL norm_ready got %b want 0", m_launch_ready); end
        step();
        n_checks += 3;
        if (m_kernel_reset !== 1'b0) begin n_fail++; $display("FAIL norm_clear_once got %b want 0", m_kernel_reset); end
        if (m_dcr_we !== 1'b1) begin n_fail++; $display("FAIL norm_dcr_we got %b want 1", m_dcr_we); end
        if (m_dcr_data !== 8'd8) begin n_fail++; $display("FAIL norm_dcr_data got %0d want 8", m_dcr_data); end
        step();
        n_checks += 2;
        if (m_dcr_we !== 1'b0 || m_dcr_data !== 8'd0) begin
            n_fail++; $display("FAIL norm_settle_dcr got we=%b data=%0d want 0 0", m_dcr_we, m_dcr_data);
        end
        if (m_kernel_start !== 1'b0) begin n_fail++; $display("FAIL norm_settle_start got %b want 0", m_kernel_start); end
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 5) kernel_done = 1'b1;
            n_checks += 2;
            if (m_kernel_start !== 1'b1) begin n_fail++; $display("FAIL norm_run_start[%0d] got %b want 1", k, m_kernel_start); end
            if (m_status_cycles !== 16'(k - 1)) begin
                n_fail++; $display("FAIL norm_run_cycles[%0d] got %0d want %0d", k, m_status_cycles, k - 1);
            end
        end
        step();
        kernel_done = 1'b0;
        n_checks += 5;
        if (m_status_valid !== 1'b1) begin n_fail++; $display("FAIL norm_status_valid got %b want 1", m_status_valid); end
        if (m_status_cycles !== 16'd5) begin n_fail++; $display("FAIL norm_cycles got %0d want 5", m_status_cycles); end
        if (m_status_timeout !== 1'b0) begin n_fail++; $display("FAIL norm_timeout got %b want 0", m_status_timeout); end
        if (m_kernel_start !== 1'b0) begin n_fail++; $display("FAIL norm_report_start got %b want 0", m_kernel_start); end
        if (m_kernel_reset !== 1'b0) begin n_fail++; $display("FAIL norm_report_kreset got %b want 0", m_kernel_reset); end
        step();
        n_checks += 3;
        if (m_status_valid !== 1'b0) begin n_fail++; $display("FAIL norm_valid_pulse got %b want 0", m_status_valid); end
        if (m_launch_ready !== 1'b1) begin n_fail++; $display("FAIL norm_idle_ready got %b want 1", m_launch_ready); end
        if (m_status_cycles !== 16'd5) begin n_fail++; $display("FAIL norm_cycles_hold got %0d want 5", m_status_cycles); end
    endtask

    task automatic test_zero_threads();
        apply_reset();
        launch_thread_count = 8'd0;
        launch_valid = 1'b1;
        step();
        launch_valid = 1'b0;
        step();
        n_checks += 2;
        if (m_dcr_we !== 1'b1) begin n_fail++; $display("FAIL zero_dcr_we got %b want 1", m_dcr_we); end
        if (m_dcr_data !== 8'd0) begin n_fail++; $display("FAIL zero_dcr_data got %0d want 0", m_dcr_data); end
        step();
        n_checks += 3;
        if (m_status_valid !== 1'b1) begin n_fail++; $display("FAIL zero_status_valid got %b want 1", m_status_valid); end
        if (m_status_cycles !== 16'd0) begin n_fail++; $display("FAIL zero_cycles got %0d want 0", m_status_cycles); end
        if (m_kernel_start !== 1'b0) begin n_fail++; $display("FAIL zero_start got %b want 0", m_kernel_start); end
        step();
        n_checks++;
        if (m_kernel_start !== 1'b0 || m_busy !== 1'b0) begin
            n_fail++; $display("FAIL zero_idle got start=%b busy=%b want 0 0", m_kernel_start, m_busy);
        end
    endtask

    task automatic test_watchdog();
        apply_reset();
        launch_thread_count = 8'd2;
        launch_valid = 1'b1;
        step();
        launch_valid = 1'b0;
        step(); step();
        for (int k = 1; k <= 4; k++) begin
            step();
            n_checks++;
            if (w_kernel_start !== 1'b1) begin n_fail++; $display("FAIL wd_run[%0d] got %b want 1", k, w_kernel_start); end
        end
        step();
        n_checks += 5;
        if (w_status_valid !== 1'b1) begin n_fail++; $display("FAIL wd_status_valid got %b want 1", w_status_valid); end
        if (w_status_timeout !== 1'b1) begin n_fail++; $display("FAIL wd_timeout got %b want 1", w_status_timeout); end
        if (w_kernel_reset !== 1'b1) begin n_fail++; $display("FAIL wd_kreset got %b want 1", w_kernel_reset); end
        if (w_status_cycles !== 16'd4) begin n_fail++; $display("FAIL wd_cycles got %0d want 4", w_status_cycles); end
        if (w_kernel_start !== 1'b0) begin n_fail++; $display("FAIL wd_start got %b want 0", w_kernel_start); end
        step();
        n_checks += 2;
        if (w_status_timeout !== 1'b1) begin n_fail++; $display("FAIL wd_timeout_hold got %b want 1", w_status_timeout); end
        if (w_kernel_reset !== 1'b0) begin n_fail++; $display("FAIL wd_kreset_once got %b want 0", w_kernel_reset); end
    endtask

    task automatic test_collision();
        apply_reset();
        launch_thread_count = 8'd1;
        launch_valid = 1'b1;
        step();
        launch_valid = 1'b0;
        step(); step();
        step(); step(); step(); step();
        kernel_done = 1'b1;
        step();
        kernel_done = 1'b0;
        n_checks += 4;
        if (w_status_valid !== 1'b1) begin n_fail++; $display("FAIL coll_status_valid got %b want 1", w_status_valid); end
        if (w_status_timeout !== 1'b0) begin n_fail++; $display("FAIL coll_timeout got %b want 0", w_status_timeout); end
        if (w_kernel_reset !== 1'b0) begin n_fail++; $display("FAIL coll_kreset got %b want 0", w_kernel_reset); end
        if (w_status_cycles !== 16'd4) begin n_fail++; $display("FAIL coll_cycles got %0d want 4", w_status_cycles); end
    endtask

    task automatic test_hold_request();
        apply_reset();
        launch_thread_count = 8'd6;
        launch_valid = 1'b1;
        step(); step(); step(); step();
        n_checks++;
        if (m_launch_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready_run got %b want 0", m_launch_ready); end
        step();
        kernel_done = 1'b1;
        step();
        kernel_done = 1'b0;
        n_checks += 2;
        if (m_status_valid !== 1'b1) begin n_fail++; $display("FAIL hold_status_valid got %b want 1", m_status_valid); end
        if (m_status_cycles !== 16'd2) begin n_fail++; $display("FAIL hold_cycles got %0d want 2", m_status_cycles); end
        step();
        n_checks++;
        if (m_launch_ready !== 1'b1) begin n_fail++; $display("FAIL hold_idle_ready got %b want 1", m_launch_ready); end
        step();
        launch_valid = 1'b0;
        n_checks += 2;
        if (m_kernel_reset !== 1'b1) begin n_fail++; $display("FAIL hold_reaccept got %b want 1", m_kernel_reset); end
        if (m_status_cycles !== 16'd0) begin n_fail++; $display("FAIL hold_cycles_clr got %0d want 0", m_status_cycles); end
        step();
        n_checks++;
        if (m_dcr_we !== 1'b1 || m_dcr_data !== 8'd6) begin
            n_fail++; $display("FAIL hold_dcr got we=%b data=%0d want 1 6", m_dcr_we, m_dcr_data);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        launch_thread_count = 8'd5;
        launch_valid = 1'b1;
        step();
        launch_valid = 1'b0;
        step(); step(); step();
        kernel_done = 1'b1;
        step();
        kernel_done = 1'b0;
        n_checks++;
        if (m_status_valid !== 1'b1 || m_status_cycles !== 16'd1) begin
            n_fail++; $display("FAIL b2b_first got valid=%b cycles=%0d want 1 1", m_status_valid, m_status_cycles);
        end
        launch_thread_count = 8'd3;
        launch_valid = 1'b1;
        step();
        n_checks += 2;
        if (m_launch_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_ready got %b want 1", m_launch_ready); end
        if (m_status_cycles !== 16'd1) begin n_fail++; $display("FAIL b2b_idle_cycles got %0d want 1", m_status_cycles); end
        step();
        launch_valid = 1'b0;
        n_checks += 2;
        if (m_kernel_reset !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got %b want 1", m_kernel_reset); end
        if (m_status_cycles !== 16'd0) begin n_fail++; $display("FAIL b2b_cycles_clr got %0d want 0", m_status_cycles); end
        step();
        n_checks++;
        if (m_dcr_we !== 1'b1 || m_dcr_data !== 8'd3) begin
            n_fail++; $display("FAIL b2b_dcr got we=%b data=%0d want 1 3", m_dcr_we, m_dcr_data);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_zero_threads();
        test_watchdog();
        test_collision();
        test_hold_request();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
